// File: rtl/ctr_stream_engine.sv
// Counter-mode stream engine: passthrough, add or keystream-XOR of an input FIFO stream.
// Define CTR_BITREV_EN to bit-reverse each keystream word before the XOR.
module ctr_stream_engine #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned CORE_LAT = 20,
    parameter int unsigned KS_DEPTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              empty,
    input  logic [DATA_W-1:0] data_in,
    input  logic              last,
    output logic              valid_fifoin,
    input  logic              full,
    output logic              valid_fifoout,
    output logic [DATA_W-1:0] data_out,
    output logic              last_out,
    input  logic [31:0]       configuration,
    input  logic [DATA_W-1:0] start_counter,
    input  logic [DATA_W-1:0] parameter_add,
    output logic              busy,
    output logic              core_en,
    output logic [DATA_W-1:0] core_state,
    input  logic [DATA_W-1:0] core_out
);

    localparam int unsigned PW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
    localparam int unsigned CW = $clog2(CORE_LAT + KS_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    typedef enum logic [1:0] {M_PASS, M_ADD, M_XOR} mode_t;

    state_t              state;
    mode_t               mode;
    logic [DATA_W-1:0]   counter;
    logic [CORE_LAT-1:0] in_flight;
    logic [CW-1:0]       inf_cnt;
    logic [CW-1:0]       ks_count;
    logic [DATA_W-1:0]   ks_mem [KS_DEPTH];
    logic [PW-1:0]       ks_rd;
    logic [PW-1:0]       ks_wr;
    logic                stage_valid;

    logic                ks_exit;
    logic                stage_free;
    logic                pop;
    logic                pop_ks;
    logic                end_pkt;
    logic                issue;
    logic                ks_push;
    logic [CW:0]         occ_next;
    logic [DATA_W-1:0]   ks_word;
    logic [DATA_W-1:0]   result;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(KS_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef CTR_BITREV_EN
    always_comb begin
        ks_word = '0;
        for (int unsigned i = 0; i < DATA_W; i++)
            ks_word[i] = ks_mem[ks_rd][DATA_W-1-i];
    end
`else
    always_comb ks_word = ks_mem[ks_rd];
`endif

    always_comb begin
        core_en    = (state != IDLE);
        busy       = (state != IDLE);
        ks_exit    = core_en && in_flight[CORE_LAT-1];
        stage_free = !stage_valid || !full;
        pop        = (state == RUN) && !empty && stage_free &&
                     ((mode != M_XOR) || (ks_count != '0));
        pop_ks     = pop && (mode == M_XOR);
        end_pkt    = pop && last;
        // Word popped this cycle frees its slot, so issue can keep pace when KS_DEPTH == CORE_LAT.
        occ_next   = {1'b0, inf_cnt} + {1'b0, ks_count} - (CW+1)'(pop_ks);
        issue      = (state == RUN) && (mode == M_XOR) && !end_pkt &&
                     (occ_next < (CW+1)'(KS_DEPTH));
        ks_push    = ks_exit && (state == RUN) && !end_pkt;
        core_state = issue ? counter : '0;
        valid_fifoin  = pop;
        valid_fifoout = stage_valid && !full;
        case (mode)
            M_ADD:   result = data_in + parameter_add;
            M_XOR:   result = data_in ^ ks_word;
            default: result = data_in;
        endcase
    end

    always_ff @(posedge clk)
        if (ks_push) ks_mem[ks_wr] <= core_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mode        <= M_PASS;
            counter     <= '0;
            in_flight   <= '0;
            inf_cnt     <= '0;
            ks_count    <= '0;
            ks_rd       <= '0;
            ks_wr       <= '0;
            stage_valid <= 1'b0;
            data_out    <= '0;
            last_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    state   <= RUN;
                    counter <= start_counter;
                    mode    <= (configuration == 32'd1) ? M_ADD :
                               (configuration == 32'd2) ? M_XOR : M_PASS;
                end
                RUN: begin
                    if (end_pkt) state <= FLUSH;
                    if (issue) counter <= counter + 1'b1;
                end
                FLUSH: if (inf_cnt == '0 && !stage_valid) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (core_en) begin
                in_flight <= (in_flight << 1) | CORE_LAT'(issue);
                inf_cnt   <= inf_cnt + CW'(issue) - CW'(ks_exit);
            end

            if (end_pkt) begin
                ks_rd    <= '0;
                ks_wr    <= '0;
                ks_count <= '0;
            end else begin
                if (ks_push) ks_wr <= ptr_next(ks_wr);
                if (pop_ks)  ks_rd <= ptr_next(ks_rd);
                ks_count <= ks_count + CW'(ks_push) - CW'(pop_ks);
            end

            if (pop) begin
                stage_valid <= 1'b1;
                data_out    <= result;
                last_out    <= last;
            end else if (!full) begin
                stage_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ctr_stream_engine.sv
// Randomized bench for ctr_stream_engine with a queue-based packet model and a modelled cipher core.
module tb_ctr_stream_engine;

    localparam int unsigned W   = 128;
    localparam int unsigned LAT = 20;
    localparam int unsigned KSD = 32;
    localparam logic [W-1:0] KEY = 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         empty = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         last = 1'b0;
    logic         valid_fifoin;
    logic         full = 1'b0;
    logic         valid_fifoout;
    logic [W-1:0] data_out;
    logic         last_out;
    logic [31:0]  configuration = '0;
    logic [W-1:0] start_counter = '0;
    logic [W-1:0] parameter_add = '0;
    logic         busy;
    logic         core_en;
    logic [W-1:0] core_state;
    logic [W-1:0] core_out;

    ctr_stream_engine #(.DATA_W(W), .CORE_LAT(LAT), .KS_DEPTH(KSD)) dut (
        .clk(clk), .reset(reset), .empty(empty), .data_in(data_in), .last(last),
        .valid_fifoin(valid_fifoin), .full(full), .valid_fifoout(valid_fifoout),
        .data_out(data_out), .last_out(last_out), .configuration(configuration),
        .start_counter(start_counter), .parameter_add(parameter_add), .busy(busy),
        .core_en(core_en), .core_state(core_state), .core_out(core_out)
    );

    always #5 clk = ~clk;

    // Cipher core stand-in: fixed-latency pipeline advancing on core_en, output = counter ^ KEY.
    logic [W-1:0] core_pipe [LAT];
    always @(posedge clk)
        if (core_en) begin
            for (int i = LAT - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
            core_pipe[0] <= core_state;
        end
    assign core_out = core_pipe[LAT-1] ^ KEY;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } word_t;

    word_t        in_q[$];
    word_t        exp_q[$];
    int           wr_cyc[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           max_occ = 0;
    int           gap_pct = 0;
    int           full_pct = 0;
    bit           force_full = 1'b0;
    bit           scramble = 1'b0;
    bit           lat_armed = 1'b0;
    int           lat_start = -1;
    int           lat_first = -1;
    logic [31:0]  cur_cfg = '0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w = '0;
        for (int i = 0; i < int'((W + 31) / 32); i++) w = (w << 32) | W'($urandom);
        return w;
    endfunction

    function automatic logic [W-1:0] ref_word(input logic [31:0] cfg, input logic [W-1:0] d,
                                              input logic [W-1:0] st, input logic [W-1:0] add,
                                              input int idx);
        logic [W-1:0] ks = (st + W'(idx)) ^ KEY;
`ifdef CTR_BITREV_EN
        logic [W-1:0] r = '0;
        for (int i = 0; i < int'(W); i++) r[i] = ks[int'(W) - 1 - i];
        ks = r;
`endif
        case (cfg)
            32'd1:   return d + add;
            32'd2:   return d ^ ks;
            default: return d;
        endcase
    endfunction

    // base != 0 gives data words base, base+1, ...; otherwise random.
    task automatic add_packet(input logic [31:0] cfg, input logic [W-1:0] st,
                              input logic [W-1:0] add, input int n, input logic [W-1:0] base);
        word_t w;
        cur_cfg = cfg;
        start_counter = st;
        parameter_add = add;
        for (int i = 0; i < n; i++) begin
            w.data = (base != '0) ? base + W'(i) : rand_word();
            w.last = (i == n - 1);
            in_q.push_back(w);
            exp_q.push_back('{ref_word(cfg, w.data, st, add, i), w.last});
        end
    endtask

    task automatic cycle();
        int occ;
        @(posedge clk); #1;
        configuration = (busy && scramble) ? $urandom : cur_cfg;
        empty = (in_q.size() == 0) || ($urandom_range(0, 99) < gap_pct);
        if (!empty) begin
            data_in = in_q[0].data;
            last = in_q[0].last;
        end else begin
            data_in = rand_word();
            last = 1'b0;
        end
        full = force_full || ($urandom_range(0, 99) < full_pct);
        @(negedge clk);
        cyc++;
        occ = int'(dut.inf_cnt) + int'(dut.ks_count);
        if (occ > max_occ) max_occ = occ;
        if (lat_armed && lat_start < 0 && !busy && !empty) lat_start = cyc;
        if (lat_armed && lat_first < 0 && valid_fifoin) lat_first = cyc;
        if (empty) check("rd_on_empty", valid_fifoin, 1'b0);
        else if (valid_fifoin) void'(in_q.pop_front());
        if (full) check("wr_on_full", valid_fifoout, 1'b0);
        if (valid_fifoout) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("spurious_wr", valid_fifoout, 1'b0);
            else begin
                word_t e = exp_q.pop_front();
                check("data_out", data_out, e.data);
                check("last_out", last_out, e.last);
            end
        end
    endtask

    task automatic run_until_done();
        int guard = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && guard < 4000) begin
            cycle();
            guard++;
        end
        if (guard >= 4000) begin
            check("timeout", 1'b1, 1'b0);
            in_q.delete();
            exp_q.delete();
        end
        repeat (LAT + 4) cycle();
        check("idle_busy", busy, 1'b0);
        check("idle_core_en", core_en, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_valid_fifoin", valid_fifoin, 1'b0);
        check("rst_valid_fifoout", valid_fifoout, 1'b0);
        check("rst_data_out", data_out, '0);
        check("rst_last_out", last_out, 1'b0);
        check("rst_core_en", core_en, 1'b0);
        check("rst_core_state", core_state, '0);
        check("rst_busy", busy, 1'b0);
    endtask

    initial begin
        logic [31:0] cfgs [6] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd7, 32'hFFFF_FFFF};

        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;
        repeat (2) cycle();

        // Passthrough 1,2,3,4 with back-to-back write strobes.
        wr_cyc.delete();
        add_packet(32'd0, '0, '0, 4, W'(1));
        run_until_done();
        check("pass_count", W'(wr_cyc.size()), W'(4));
        for (int i = 1; i < wr_cyc.size(); i++)
            check("pass_consecutive", W'(wr_cyc[i] - wr_cyc[i-1]), W'(1));

        // Add mode wraps: 2 + all-ones = 1.
        add_packet(32'd1, '0, '1, 1, W'(2));
        run_until_done();

        // Counter wrap across 2^W and first-read latency.
        lat_armed = 1'b1; lat_start = -1; lat_first = -1;
        add_packet(32'd2, '1 - W'(1), '0, 3, '0);
        run_until_done();
        lat_armed = 1'b0;
        check("first_rd_latency_ok", W'((lat_start >= 0) && (lat_first - lat_start >= int'(LAT) + 1)), W'(1));

        // Output full held for 10 cycles mid-packet.
        add_packet(32'd2, rand_word(), '0, 40, '0);
        repeat (30) cycle();
        force_full = 1'b1;
        repeat (10) cycle();
        if (exp_q.size() > 0) check("hold_data_out", data_out, exp_q[0].data);
        force_full = 1'b0;
        run_until_done();

        // Two back-to-back keystream packets from the same start counter.
        begin
            logic [W-1:0] st = rand_word();
            add_packet(32'd2, st, '0, 5, '0);
            add_packet(32'd2, st, '0, 6, '0);
            run_until_done();
        end

        // Reset in the middle of a keystream packet, then a clean packet.
        gap_pct = 10;
        add_packet(32'd2, rand_word(), '0, 20, '0);
        repeat (30) cycle();
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_reset_outputs();
        in_q.delete();
        exp_q.delete();
        repeat (3) cycle();
        reset = 1'b1;
        repeat (2) cycle();
        add_packet(32'd2, rand_word(), '0, 8, '0);
        run_until_done();

        // Randomized traffic with stalls, back-pressure and config churn during packets.
        gap_pct = 20; full_pct = 25; scramble = 1'b1;
        for (int p = 0; p < 25; p++) begin
            logic [31:0] cfg = cfgs[$urandom_range(0, 5)];
            logic [W-1:0] st = rand_word();
            logic [W-1:0] add = rand_word();
            add_packet(cfg, st, add, $urandom_range(1, 12), '0);
            if ($urandom_range(0, 99) < 30) add_packet(cfg, st, add, $urandom_range(1, 12), '0);
            run_until_done();
        end

        check("ks_occupancy_bound", W'(max_occ <= int'(KSD)), W'(1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
